uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter: internal FIFO, 16x baud-enable generator and framing FSM in one block.
//  Data width, parity mode, stop-bit count and FIFO depth are set at elaboration.
//  Adds FIFO occupancy, a busy flag and back-to-back framing with no idle gap.
//  Sits between the host write path and the txd pad, in the same place as the fixed 8N1 transmitter.
// PARAMETERS
//  BAUD_RATE   57_600      serial bit rate (bps)
//  CLOCK_RATE  50_000_000  clk_tx frequency (Hz)
//  DATA_BITS   8           payload bits per frame, legal 5..8
//  PARITY      0           0 none, 1 even, 2 odd
//  STOP_BITS   1           legal 1 or 2
//  FIFO_DEPTH  16          entries, power of 2, >=2; AW = $clog2(FIFO_DEPTH)
// PORTS
//  clk_tx              in   1            clock
//  rst_clk_tx          in   1            reset, asynchronous, active-high
//  tx_din              in   DATA_BITS    character to queue
//  write_en            in   1            push tx_din into the FIFO
//  tx_fifo_full        out  1            FIFO holds FIFO_DEPTH entries
//  tx_fifo_empty       out  1            FIFO holds 0 entries
//  tx_fifo_count       out  AW+1         current occupancy, 0..FIFO_DEPTH
//  txd_tx              out  1            serial output, idle high
//  tx_busy             out  1            FSM is not in IDLE
//  tx_frame_indicator  out  2            00 idle, 01 start, 10 data, 11 parity/stop
//  tx_bit_indicator    out  1            1-clk pulse at the mid-point of every transmitted bit
// BEHAVIOUR
//  Reset (async): txd_tx=1, tx_busy=0, indicators=0, FIFO flushed (count=0, empty=1, full=0).
//   Reset mid-frame aborts the frame at once; txd_tx goes high in the same cycle.
//  Baud gen: DIV = (CLOCK_RATE + 8*BAUD_RATE) / (16*BAUD_RATE), rounded.
//   Counter runs 0..DIV-1; baud_x16_en is a 1-clk pulse when the counter equals DIV-1.
//   The counter is free-running from reset.
//  FIFO writes:
//   - Push when write_en=1 and full=0.
//   - write_en while full is dropped silently, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle leave the count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FIFO reads: the FIFO is read only by the FSM (pop). All outputs are registered.
//  FSM states and transitions (all evaluated on baud_x16_en; os = 4-bit oversample counter):
//   IDLE:
//    - If FIFO is not empty: load the shift register from the head, pop, compute parity,
//      set txd_tx=0, os=0, go to START.
//    - Otherwise hold txd_tx=1.
//   START/DATA/PARITY/STOP: each bit lasts 16 enables (os 0..15); leave the state at os==15.
//   START -> DATA.
//   DATA: txd_tx = shift[0], LSB first.
//    - Shift on each bit boundary.
//    - After DATA_BITS bits go to PARITY if PARITY!=0, else to STOP.
//   PARITY: txd_tx = ^data (even) or ~^data (odd). Parity covers DATA_BITS bits only.
//   STOP: txd_tx=1 for STOP_BITS bit times.
//    - At the final os==15: if FIFO is not empty, pop and enter START directly (no idle gap).
//    - Otherwise go to IDLE.
//  Frame length = 16*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) enables.
//  Start latency: a write into an empty FIFO with the FSM idle drives txd_tx low
//   at most DIV+2 clk after write_en.
//  tx_bit_indicator: pulses on baud_x16_en with os==7 in every non-IDLE state.
//  tx_busy=1 from the START entry until the return to IDLE.
// TESTING  (CLOCK_RATE=1_600_000, BAUD_RATE=25_000 -> DIV=4, 64 clk per bit)
//  8N1, write 0xA5 -> txd_tx 0,1,0,1,0,0,1,0,1,1, each 64 clk; tx_busy high for 640 clk; frame ind 01,10x8,11.
//  7E2, write 0x35 -> txd_tx 0,1,0,1,0,1,1,0, parity 0, 1,1; 11 bits total.
//  8O1, write 0xFF -> parity bit 1; write 0x00 -> parity bit 1; write 0x01 -> parity bit 0.
//  FIFO_DEPTH=16, 18 writes on consecutive clocks -> one popped early, full asserted, 1 dropped;
//   17 frames back-to-back with no idle gap; count decrements once per frame.
//  Assert rst_clk_tx mid DATA bit -> txd_tx=1 in the same cycle, count=0, tx_busy=0, no frame after release.
//  write_en while full and the FSM popping in the same cycle -> data dropped, count drops by 1.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   Parametrised UART transmitter. Characters written by the host are queued in
//   an internal FIFO. A framing FSM drains the FIFO and serialises each
//   character as start / data (LSB first) / optional parity / stop bits. The FSM
//   is paced by a 16x oversampling enable.
//   Consecutive characters are framed back to back with no idle gap.
//
// Parameters
//   BAUD_RATE   serial bit rate in bps
//   CLOCK_RATE  clk_tx frequency in Hz
//   DATA_BITS   payload bits per frame (5..8)
//   PARITY      0 none, 1 even, 2 odd
//   STOP_BITS   1 or 2
//   FIFO_DEPTH  queue entries, power of two, >= 2
//
// Ports
//   clk_tx              clock
//   rst_clk_tx          asynchronous active-high reset
//   tx_din              character to queue
//   write_en            push tx_din (ignored while the FIFO is full)
//   tx_fifo_full        FIFO holds FIFO_DEPTH entries
//   tx_fifo_empty       FIFO holds no entries
//   tx_fifo_count       FIFO occupancy, 0..FIFO_DEPTH
//   txd_tx              serial output, idle high
//   tx_busy             a frame is in progress
//   tx_frame_indicator  00 idle, 01 start, 10 data, 11 parity/stop
//   tx_bit_indicator    one-clock pulse at the middle of each transmitted bit
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int BAUD_RATE  = 57_600,
  parameter int CLOCK_RATE = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_tx,
  input  logic                 rst_clk_tx,
  input  logic [DATA_BITS-1:0] tx_din,
  input  logic                 write_en,
  output logic                 tx_fifo_full,
  output logic                 tx_fifo_empty,
  output logic [AW:0]          tx_fifo_count,
  output logic                 txd_tx,
  output logic                 tx_busy,
  output logic [1:0]           tx_frame_indicator,
  output logic                 tx_bit_indicator
);

  // Rounded divider from clk_tx down to 16x the bit rate
  localparam int DIV = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  localparam logic [AW:0] CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ZERO  = {(AW + 1){1'b0}};
  localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  // Framing FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [1:0] FI_IDLE  = 2'b00;
  localparam logic [1:0] FI_START = 2'b01;
  localparam logic [1:0] FI_DATA  = 2'b10;
  localparam logic [1:0] FI_TAIL  = 2'b11;

  // Parity over the payload only; odd mode inverts the even result
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 2) begin
      calc_parity = ~p;
    end else begin
      calc_parity = p;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Baud-enable generator
  // ---------------------------------------------------------------------------
  logic [DW-1:0] baud_cnt_r;
  logic          baud_en_s;

  assign baud_en_s = (baud_cnt_r == DIV_LAST);

  // Free-running divider counter, wraps at DIV-1
  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      baud_cnt_r <= {DW{1'b0}};
    end else if (baud_en_s) begin
      baud_cnt_r <= {DW{1'b0}};
    end else begin
      baud_cnt_r <= baud_cnt_r + DIV_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          count_r;
  logic [AW:0]          count_nxt;
  logic                 full_r;
  logic                 empty_r;
  logic                 push_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  // A write while full is dropped even if the FSM pops in the same cycle
  assign push_s = write_en & ~full_r;
  assign head_s = mem_r[rd_ptr_r];

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt = count_r + CNT_ONE;
      2'b01:   count_nxt = count_r - CNT_ONE;
      default: count_nxt = count_r;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates all reads
  always_ff @(posedge clk_tx) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_din;
    end
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt;
      full_r  <= (count_nxt == CNT_FULL);
      empty_r <= (count_nxt == CNT_ZERO);
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  logic [2:0]           state_r,    state_nxt;
  logic [3:0]           os_r,       os_nxt;
  logic [2:0]           bit_cnt_r,  bit_cnt_nxt;
  logic                 stop_cnt_r, stop_cnt_nxt;
  logic [DATA_BITS-1:0] shift_r,    shift_nxt;
  logic                 par_r,      par_nxt;
  logic                 txd_r,      txd_nxt;
  logic                 busy_r,     busy_nxt;
  logic [1:0]           frame_r,    frame_nxt;
  logic                 bit_ind_r,  bit_ind_nxt;
  logic                 os_last_s;
  logic                 load_s;

  assign os_last_s = (os_r == 4'd15);

  // Next-state logic; everything advances only on the 16x enable
  always_comb begin
    state_nxt    = state_r;
    os_nxt       = os_r;
    bit_cnt_nxt  = bit_cnt_r;
    stop_cnt_nxt = stop_cnt_r;
    shift_nxt    = shift_r;
    par_nxt      = par_r;
    txd_nxt      = txd_r;
    busy_nxt     = busy_r;
    frame_nxt    = frame_r;
    load_s       = 1'b0;
    pop_s        = 1'b0;
    bit_ind_nxt  = baud_en_s & (state_r != S_IDLE) & (os_r == 4'd7);

    if (baud_en_s) begin
      os_nxt = os_r + 4'd1;
      case (state_r)
        S_IDLE: begin
          os_nxt = 4'd0;
          if (!empty_r) begin
            load_s = 1'b1;
          end else begin
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            frame_nxt = FI_IDLE;
          end
        end
        S_START: begin
          if (os_last_s) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 3'd0;
            txd_nxt     = shift_r[0];
            frame_nxt   = FI_DATA;
          end else begin
            state_nxt = S_START;
          end
        end
        S_DATA: begin
          if (os_last_s) begin
            if (bit_cnt_r == DATA_LAST) begin
              frame_nxt = FI_TAIL;
              if (PARITY != 0) begin
                state_nxt = S_PARITY;
                txd_nxt   = par_r;
              end else begin
                state_nxt    = S_STOP;
                stop_cnt_nxt = 1'b0;
                txd_nxt      = 1'b1;
              end
            end else begin
              // Shift on the bit boundary; the new LSB drives the line next
              bit_cnt_nxt = bit_cnt_r + 3'd1;
              shift_nxt   = {1'b0, shift_r[DATA_BITS-1:1]};
              txd_nxt     = shift_r[1];
            end
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_PARITY: begin
          if (os_last_s) begin
            state_nxt    = S_STOP;
            stop_cnt_nxt = 1'b0;
            txd_nxt      = 1'b1;
          end else begin
            state_nxt = S_PARITY;
          end
        end
        S_STOP: begin
          if (os_last_s) begin
            if (stop_cnt_r == STOP_LAST) begin
              if (!empty_r) begin
                // Chain straight into the next start bit
                load_s = 1'b1;
              end else begin
                state_nxt = S_IDLE;
                txd_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                frame_nxt = FI_IDLE;
              end
            end else begin
              stop_cnt_nxt = stop_cnt_r + 1'b1;
            end
          end else begin
            state_nxt = S_STOP;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          os_nxt    = 4'd0;
          txd_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          frame_nxt = FI_IDLE;
        end
      endcase

      // Common frame start: take the FIFO head and drive the start bit
      if (load_s) begin
        pop_s     = 1'b1;
        shift_nxt = head_s;
        par_nxt   = calc_parity(head_s);
        txd_nxt   = 1'b0;
        os_nxt    = 4'd0;
        state_nxt = S_START;
        busy_nxt  = 1'b1;
        frame_nxt = FI_START;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      state_nxt = state_r;
    end
  end

  // FSM and output registers; reset returns the line to idle immediately
  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      state_r    <= S_IDLE;
      os_r       <= 4'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      frame_r    <= FI_IDLE;
      bit_ind_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      os_r       <= os_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      stop_cnt_r <= stop_cnt_nxt;
      shift_r    <= shift_nxt;
      par_r      <= par_nxt;
      txd_r      <= txd_nxt;
      busy_r     <= busy_nxt;
      frame_r    <= frame_nxt;
      bit_ind_r  <= bit_ind_nxt;
    end
  end

  assign tx_fifo_full       = full_r;
  assign tx_fifo_empty      = empty_r;
  assign tx_fifo_count      = count_r;
  assign txd_tx             = txd_r;
  assign tx_busy            = busy_r;
  assign tx_frame_indicator = frame_r;
  assign tx_bit_indicator   = bit_ind_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Scoreboard bench for uart_tx_cfg. Three instances (8N1, 7E2, 8O1) run at
//   DIV=4, i.e. 64 clocks per bit. Written characters are pushed to an
//   expected queue. A sampling receiver decodes txd at mid-bit, pops the queue
//   and compares data, parity, stop bits, indicators and FIFO occupancy.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din   [3];
  logic       we    [3];
  logic       full  [3];
  logic       empty [3];
  logic [4:0] cnt   [3];
  logic       txd   [3];
  logic       busy  [3];
  logic [1:0] fi    [3];
  logic       bi    [3];

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  int bi_cnt   [3] = '{0, 0, 0};
  int busy_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_tx_cfg #(.BAUD_RATE(25_000), .CLOCK_RATE(1_600_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_din(din[0]), .write_en(we[0]),
    .tx_fifo_full(full[0]), .tx_fifo_empty(empty[0]), .tx_fifo_count(cnt[0]),
    .txd_tx(txd[0]), .tx_busy(busy[0]), .tx_frame_indicator(fi[0]),
    .tx_bit_indicator(bi[0]));

  uart_tx_cfg #(.BAUD_RATE(25_000), .CLOCK_RATE(1_600_000), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7e2 (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_din(din[1][6:0]), .write_en(we[1]),
    .tx_fifo_full(full[1]), .tx_fifo_empty(empty[1]), .tx_fifo_count(cnt[1]),
    .txd_tx(txd[1]), .tx_busy(busy[1]), .tx_frame_indicator(fi[1]),
    .tx_bit_indicator(bi[1]));

  uart_tx_cfg #(.BAUD_RATE(25_000), .CLOCK_RATE(1_600_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_din(din[2]), .write_en(we[2]),
    .tx_fifo_full(full[2]), .tx_fifo_empty(empty[2]), .tx_fifo_count(cnt[2]),
    .txd_tx(txd[2]), .tx_busy(busy[2]), .tx_frame_indicator(fi[2]),
    .tx_bit_indicator(bi[2]));

  // Per-instance counters of busy clocks and bit-indicator pulses
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bi[k] === 1'b1) bi_cnt[k] = bi_cnt[k] + 1;
      if (busy[k] === 1'b1) busy_cnt[k] = busy_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic wr(input int k, input logic [7:0] v, input logic [7:0] mask);
    din[k] = v;
    we[k]  = 1'b1;
    exp_q.push_back(v & mask);
    @(negedge clk);
    we[k]  = 1'b0;
  endtask

  // Receive one frame on instance k; max_wait bounds the clocks to the start edge
  task automatic rx_frame(input int k, input int dbits, input int par, input int stops,
                          input int max_wait, input int exp_cnt);
    int w;
    int ones;
    logic [7:0] d;
    logic [7:0] e;
    logic exp_p;
    w = 0;
    d = 8'h00;
    while (txd[k] !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", 32'(txd[k]), 32'd0);
    if (txd[k] !== 1'b0) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    repeat (32) @(negedge clk);
    check("start_bit", 32'(txd[k]), 32'd0);
    check("start_ind", 32'(fi[k]), 32'd1);
    check("start_busy", 32'(busy[k]), 32'd1);
    if (exp_cnt >= 0) check("fifo_count", 32'(cnt[k]), 32'(exp_cnt));
    for (int i = 0; i < dbits; i++) begin
      repeat (64) @(negedge clk);
      d[i] = txd[k];
      check("data_ind", 32'(fi[k]), 32'd2);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 8'hxx;
    end
    check("data", 32'(d), 32'(e));
    if (par != 0) begin
      ones = 0;
      for (int i = 0; i < dbits; i++) ones += int'(e[i]);
      exp_p = (par == 1) ? ones[0] : ~ones[0];
      repeat (64) @(negedge clk);
      check("parity", 32'(txd[k]), 32'(exp_p));
      check("parity_ind", 32'(fi[k]), 32'd3);
    end
    for (int s = 0; s < stops; s++) begin
      repeat (64) @(negedge clk);
      check("stop", 32'(txd[k]), 32'd1);
      check("stop_ind", 32'(fi[k]), 32'd3);
    end
  endtask

  initial begin
    int b0;
    int p0;
    int w;
    int lows;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00;
      we[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_txd", 32'(txd[k]), 32'd1);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_ind", 32'(fi[k]), 32'd0);
      check("rst_count", 32'(cnt[k]), 32'd0);
      check("rst_empty", 32'(empty[k]), 32'd1);
      check("rst_full", 32'(full[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 single frame: latency, bit pattern, busy length, bit pulses
    b0 = busy_cnt[0];
    p0 = bi_cnt[0];
    wr(0, 8'hA5, 8'hFF);
    rx_frame(0, 8, 0, 1, 5, 0);
    repeat (64) @(negedge clk);
    check("busy_len", 32'(busy_cnt[0] - b0), 32'd640);
    check("bit_pulses_8n1", 32'(bi_cnt[0] - p0), 32'd10);
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_ind", 32'(fi[0]), 32'd0);
    check("idle_txd", 32'(txd[0]), 32'd1);

    // 7E2 frame
    p0 = bi_cnt[1];
    wr(1, 8'h35, 8'h7F);
    rx_frame(1, 7, 1, 2, 200, 0);
    repeat (96) @(negedge clk);
    check("bit_pulses_7e2", 32'(bi_cnt[1] - p0), 32'd11);
    check("idle_busy_7e2", 32'(busy[1]), 32'd0);

    // 8O1 frames queued back to back
    wr(2, 8'hFF, 8'hFF);
    wr(2, 8'h00, 8'hFF);
    wr(2, 8'h01, 8'hFF);
    rx_frame(2, 8, 2, 1, 200, 2);
    rx_frame(2, 8, 2, 1, 40, 1);
    rx_frame(2, 8, 2, 1, 40, 0);
    repeat (64) @(negedge clk);

    // Burst of 18 writes: one popped early, 16 held, last one dropped
    for (int i = 0; i < 18; i++) begin
      din[0] = 8'h30 + 8'(i);
      we[0]  = 1'b1;
      if (i < 17) exp_q.push_back(8'h30 + 8'(i));
      @(negedge clk);
    end
    we[0] = 1'b0;
    check("burst_full", 32'(full[0]), 32'd1);
    check("burst_count", 32'(cnt[0]), 32'd16);
    fork
      begin
        for (int j = 0; j < 17; j++) begin
          rx_frame(0, 8, 0, 1, (j == 0) ? 200 : 40, 16 - j);
        end
      end
      begin
        // Keep writing while full so a write lands on the pop cycle
        int t;
        t = 0;
        while (full[0] === 1'b1 && t < 2000) begin
          din[0] = 8'hEE;
          we[0]  = 1'b1;
          @(negedge clk);
          t++;
        end
        we[0] = 1'b0;
        check("full_pop_count", 32'(cnt[0]), 32'd15);
        check("full_pop_full", 32'(full[0]), 32'd0);
      end
    join
    repeat (64) @(negedge clk);
    check("drain_empty", 32'(empty[0]), 32'd1);
    check("drain_busy", 32'(busy[0]), 32'd0);

    // Reset in the middle of a data bit
    wr(0, 8'h5A, 8'hFF);
    w = 0;
    while (txd[0] !== 1'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (32 + 64 * 3) @(negedge clk);
    check("pre_rst_bit", 32'(txd[0]), 32'd0);
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd[0]), 32'd1);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_count", 32'(cnt[0]), 32'd0);
    check("mid_rst_ind", 32'(fi[0]), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (1500) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);
    check("post_rst_empty", 32'(empty[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
